// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared geometry, widths and block index layout for the block-match result path
package bm_pkg;

  localparam int DISP_W     = 6;
  localparam int COST_W     = 16;
  localparam int MAP_ADDR_W = 10;

  localparam logic [5:0] CENTER_BLOCKS_PER_ROW = 6'd17;
  localparam logic [5:0] BLOCKS_PER_COL        = 6'd29;
  localparam logic [5:0] NUM_PAD_BLOCKS        = 6'd2;
  localparam logic [5:0] THIRD_BLOCKS_PER_ROW  = 6'd15;
  localparam logic [MAP_ADDR_W-1:0] BANK_OFFSET = 10'd493;

  typedef struct packed {
    logic [3:0] img;
    logic [5:0] row;
    logic [5:0] col;
  } blk_index_t;

  // row*17 as row*16 + row keeps the address path to shifts and adds
  function automatic logic [MAP_ADDR_W-1:0] blk_addr(input blk_index_t idx);
    logic [MAP_ADDR_W-1:0] a;
    a = ({4'b0, idx.row} << 4) + {4'b0, idx.row} + {4'b0, idx.col};
    if (idx.img[0]) a = a + BANK_OFFSET;
    return a;
  endfunction

endpackage

// File: rtl/bm_lr_check.sv
// rtl/bm_lr_check.sv - combinational left/right consistency and cost threshold check
module bm_lr_check
  import bm_pkg::*;
(
  input  logic [5:0]        col_i,
  input  logic [DISP_W-1:0] disp_l_i,
  input  logic [DISP_W-1:0] disp_r_i,
  input  logic [COST_W-1:0] cost_l_i,
  input  logic [COST_W-1:0] cost_r_i,
  input  logic [DISP_W-1:0] lr_tol_i,
  input  logic [COST_W-1:0] max_cost_i,
  output logic              valid_o,
  output logic [DISP_W-1:0] disp_o
);

  logic [DISP_W:0] dl, dr, diff;
  logic            ok_l, ok_r;

  always_comb begin
    dl   = {1'b0, disp_l_i};
    dr   = {1'b0, disp_r_i};
    diff = (dl >= dr) ? (dl - dr) : (dr - dl);
    ok_l = cost_l_i <= max_cost_i;
    ok_r = cost_r_i <= max_cost_i;
    // edge columns only have one trustworthy core, so no cross check there
    if (col_i < NUM_PAD_BLOCKS) begin
      valid_o = ok_l;
      disp_o  = disp_l_i;
    end else if (col_i >= THIRD_BLOCKS_PER_ROW) begin
      valid_o = ok_r;
      disp_o  = disp_r_i;
    end else begin
      valid_o = ok_l && ok_r && (diff <= {1'b0, lr_tol_i});
      disp_o  = disp_l_i;
    end
  end

endmodule

// File: rtl/bm_result_collector.sv
// rtl/bm_result_collector.sv - pairs left/right block results by index and writes the disparity map
module bm_result_collector
  import bm_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res_valid_left,
  output logic                  res_ready_left,
  input  logic [15:0]           res_index_left,
  input  logic [DISP_W-1:0]     res_disp_left,
  input  logic [COST_W-1:0]     res_cost_left,
  input  logic                  res_valid_right,
  output logic                  res_ready_right,
  input  logic [15:0]           res_index_right,
  input  logic [DISP_W-1:0]     res_disp_right,
  input  logic [COST_W-1:0]     res_cost_right,
  input  logic [DISP_W-1:0]     lr_tol,
  input  logic [COST_W-1:0]     max_cost,
  output logic                  map_wr_en,
  output logic [MAP_ADDR_W-1:0] map_wr_addr,
  output logic [7:0]            map_wr_data,
  output logic                  frame_done,
  output logic [3:0]            frame_img,
  output logic                  err_mismatch
);

  logic                  hold_l_valid_q, hold_r_valid_q;
  blk_index_t            hold_l_idx_q, hold_r_idx_q;
  logic [DISP_W-1:0]     hold_l_disp_q, hold_r_disp_q;
  logic [COST_W-1:0]     hold_l_cost_q, hold_r_cost_q;
  logic                  wr_en_q, wr_last_q, frame_done_q, err_q;
  logic [MAP_ADDR_W-1:0] wr_addr_q;
  logic [7:0]            wr_data_q;
  logic [3:0]            wr_img_q, frame_img_q;

  logic                  pair_fire, idx_match, in_range;
  logic                  wr_en_d, wr_last_d, err_d;
  logic                  chk_valid;
  logic [DISP_W-1:0]     chk_disp;

  bm_lr_check u_lr_check (
    .col_i      (hold_l_idx_q.col),
    .disp_l_i   (hold_l_disp_q),
    .disp_r_i   (hold_r_disp_q),
    .cost_l_i   (hold_l_cost_q),
    .cost_r_i   (hold_r_cost_q),
    .lr_tol_i   (lr_tol),
    .max_cost_i (max_cost),
    .valid_o    (chk_valid),
    .disp_o     (chk_disp)
  );

  always_comb begin
    pair_fire = hold_l_valid_q && hold_r_valid_q;
    idx_match = hold_l_idx_q == hold_r_idx_q;
    in_range  = (hold_l_idx_q.row < BLOCKS_PER_COL) && (hold_l_idx_q.col < CENTER_BLOCKS_PER_ROW);
    wr_en_d   = pair_fire && idx_match && in_range;
    err_d     = err_q || (pair_fire && !(idx_match && in_range));
    wr_last_d = (hold_l_idx_q.row == BLOCKS_PER_COL - 6'd1) &&
                (hold_l_idx_q.col == CENTER_BLOCKS_PER_ROW - 6'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l_valid_q <= 1'b0;
      hold_r_valid_q <= 1'b0;
      hold_l_idx_q   <= '0;
      hold_r_idx_q   <= '0;
      hold_l_disp_q  <= '0;
      hold_r_disp_q  <= '0;
      hold_l_cost_q  <= '0;
      hold_r_cost_q  <= '0;
      wr_en_q        <= 1'b0;
      wr_last_q      <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_img_q       <= '0;
      frame_done_q   <= 1'b0;
      frame_img_q    <= '0;
      err_q          <= 1'b0;
    end else begin
      // ready is !hold_valid, so a side cannot accept on the edge its pair fires
      if (res_valid_left && !hold_l_valid_q) begin
        hold_l_valid_q <= 1'b1;
        hold_l_idx_q   <= res_index_left;
        hold_l_disp_q  <= res_disp_left;
        hold_l_cost_q  <= res_cost_left;
      end else if (pair_fire) begin
        hold_l_valid_q <= 1'b0;
      end
      if (res_valid_right && !hold_r_valid_q) begin
        hold_r_valid_q <= 1'b1;
        hold_r_idx_q   <= res_index_right;
        hold_r_disp_q  <= res_disp_right;
        hold_r_cost_q  <= res_cost_right;
      end else if (pair_fire) begin
        hold_r_valid_q <= 1'b0;
      end
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q <= blk_addr(hold_l_idx_q);
        wr_data_q <= {chk_valid, 1'b0, chk_disp};
        wr_last_q <= wr_last_d;
        wr_img_q  <= hold_l_idx_q.img;
      end
      frame_done_q <= wr_en_q && wr_last_q;
      if (wr_en_q && wr_last_q) frame_img_q <= wr_img_q;
      err_q <= err_d;
    end
  end

  assign res_ready_left  = !hold_l_valid_q;
  assign res_ready_right = !hold_r_valid_q;
  assign map_wr_en       = wr_en_q;
  assign map_wr_addr     = wr_addr_q;
  assign map_wr_data     = wr_data_q;
  assign frame_done      = frame_done_q;
  assign frame_img       = frame_img_q;
  assign err_mismatch    = err_q;

endmodule

// File: tb/tb_bm_result_collector.sv
// tb/tb_bm_result_collector.sv - scoreboard bench for the block-match result collector
module tb_bm_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid_left = 1'b0, res_valid_right = 1'b0;
  logic        res_ready_left, res_ready_right;
  logic [15:0] res_index_left = '0, res_index_right = '0;
  logic [5:0]  res_disp_left = '0, res_disp_right = '0;
  logic [15:0] res_cost_left = '0, res_cost_right = '0;
  logic [5:0]  lr_tol = '0;
  logic [15:0] max_cost = '0;
  logic        map_wr_en;
  logic [9:0]  map_wr_addr;
  logic [7:0]  map_wr_data;
  logic        frame_done;
  logic [3:0]  frame_img;
  logic        err_mismatch;

  int total = 0;
  int bad = 0;
  logic [17:0] exp_wr_q[$];
  logic [3:0]  exp_fd_q[$];
  logic [17:0] e;
  logic [3:0]  ef;
  logic        prev_last = 1'b0;

  bm_result_collector dut (
    .clk(clk), .reset(reset),
    .res_valid_left(res_valid_left), .res_ready_left(res_ready_left),
    .res_index_left(res_index_left), .res_disp_left(res_disp_left), .res_cost_left(res_cost_left),
    .res_valid_right(res_valid_right), .res_ready_right(res_ready_right),
    .res_index_right(res_index_right), .res_disp_right(res_disp_right), .res_cost_right(res_cost_right),
    .lr_tol(lr_tol), .max_cost(max_cost),
    .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .frame_done(frame_done), .frame_img(frame_img), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (map_wr_en) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", {22'b0, map_wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_addr", {22'b0, map_wr_addr}, {22'b0, e[17:8]});
        check("wr_data", {24'b0, map_wr_data}, {24'b0, e[7:0]});
      end
    end
    if (frame_done) begin
      check("frame_done_after_last_write", {31'b0, prev_last}, 32'd1);
      if (exp_fd_q.size() == 0) begin
        check("unexpected_frame_done", {28'b0, frame_img}, 32'hFFFF_FFFF);
      end else begin
        ef = exp_fd_q.pop_front();
        check("frame_img", {28'b0, frame_img}, {28'b0, ef});
      end
    end
    prev_last = map_wr_en && (map_wr_addr == 10'd492 || map_wr_addr == 10'd985);
  end

  task automatic wait_ready(input logic need_l, input logic need_r);
    int n = 0;
    while (((need_l && !res_ready_left) || (need_r && !res_ready_right)) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_left(input logic [15:0] idx, input logic [5:0] d, input logic [15:0] c);
    wait_ready(1'b1, 1'b0);
    res_index_left = idx; res_disp_left = d; res_cost_left = c; res_valid_left = 1'b1;
    @(posedge clk); #1;
    res_valid_left = 1'b0;
  endtask

  task automatic send_right(input logic [15:0] idx, input logic [5:0] d, input logic [15:0] c);
    wait_ready(1'b0, 1'b1);
    res_index_right = idx; res_disp_right = d; res_cost_right = c; res_valid_right = 1'b1;
    @(posedge clk); #1;
    res_valid_right = 1'b0;
  endtask

  task automatic send_both(input logic [15:0] il, input logic [5:0] dl, input logic [15:0] cl,
                           input logic [15:0] ir, input logic [5:0] dr, input logic [15:0] cr);
    wait_ready(1'b1, 1'b1);
    res_index_left = il;  res_disp_left = dl;  res_cost_left = cl;  res_valid_left = 1'b1;
    res_index_right = ir; res_disp_right = dr; res_cost_right = cr; res_valid_right = 1'b1;
    @(posedge clk); #1;
    res_valid_left = 1'b0;
    res_valid_right = 1'b0;
  endtask

  initial begin
    lr_tol = 6'd1;
    max_cost = 16'd500;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_left", {31'b0, res_ready_left}, 32'd1);
    check("rst_ready_right", {31'b0, res_ready_right}, 32'd1);
    check("rst_outputs", {20'b0, map_wr_en, frame_done, err_mismatch, frame_img, 5'b0}, 32'd0);
    check("rst_wr_addr_data", {14'b0, map_wr_addr, map_wr_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // same-cycle pair at index 0, plus two-cycle latency check
    exp_wr_q.push_back({10'd0, 8'h8A});
    send_both(16'h0000, 6'd10, 16'd100, 16'h0000, 6'd11, 16'd90);
    check("latency_c1_no_write", {31'b0, map_wr_en}, 32'd0);
    @(posedge clk); #1;
    check("latency_c2_write", {31'b0, map_wr_en}, 32'd1);

    // right first, img 1 row 3 col 5, disparity gap 4 over tol 2
    lr_tol = 6'd2;
    exp_wr_q.push_back({10'd549, 8'h14});
    send_right(16'h10C5, 6'd24, 16'd100);
    repeat (5) begin @(posedge clk); #1; end
    check("ready_right_while_held", {31'b0, res_ready_right}, 32'd0);
    check("ready_left_while_right_held", {31'b0, res_ready_left}, 32'd1);
    send_left(16'h10C5, 6'd20, 16'd100);

    // edge columns use one side only
    exp_wr_q.push_back({10'd17, 8'h87});
    send_both(16'h0040, 6'd7, 16'd50, 16'h0040, 6'd3, 16'hFFFF);
    exp_wr_q.push_back({10'd33, 8'h89});
    send_both(16'h0050, 6'd2, 16'hFFFF, 16'h0050, 6'd9, 16'd40);
    repeat (4) begin @(posedge clk); #1; end
    check("edge_cols_drained", exp_wr_q.size(), 32'd0);

    // full frame, img 2, bank 0
    for (int r = 0; r < 29; r++) begin
      for (int c = 0; c < 17; c++) begin
        exp_wr_q.push_back({10'(r * 17 + c), 8'h80 | 8'(c)});
        if (r == 28 && c == 16) exp_fd_q.push_back(4'd2);
        send_both({4'd2, 6'(r), 6'(c)}, 6'(c), 16'd0, {4'd2, 6'(r), 6'(c)}, 6'(c), 16'd0);
      end
    end
    repeat (5) begin @(posedge clk); #1; end
    check("frame_writes_drained", exp_wr_q.size(), 32'd0);
    check("frame_done_seen", exp_fd_q.size(), 32'd0);
    check("frame_no_err", {31'b0, err_mismatch}, 32'd0);

    // index mismatch: no write, sticky error, later pair still written
    send_both(16'h0041, 6'd5, 16'd10, 16'h0042, 6'd5, 16'd10);
    repeat (4) begin @(posedge clk); #1; end
    check("mismatch_err_set", {31'b0, err_mismatch}, 32'd1);
    exp_wr_q.push_back({10'd20, 8'h85});
    send_both(16'h0043, 6'd5, 16'd10, 16'h0043, 6'd5, 16'd10);
    repeat (4) begin @(posedge clk); #1; end
    check("mismatch_err_sticky", {31'b0, err_mismatch}, 32'd1);
    check("after_mismatch_drained", exp_wr_q.size(), 32'd0);

    // reset while left is held drops it
    send_left(16'h0081, 6'd3, 16'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("left_held_not_ready", {31'b0, res_ready_left}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_ready_left", {31'b0, res_ready_left}, 32'd1);
    check("reset_err_cleared", {31'b0, err_mismatch}, 32'd0);
    send_right(16'h0081, 6'd3, 16'd0);
    repeat (5) begin @(posedge clk); #1; end
    check("no_pair_from_dropped_left", {31'b0, res_ready_right}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_wr_q.push_back({10'd35, 8'h83});
    send_both(16'h0081, 6'd3, 16'd0, 16'h0081, 6'd3, 16'd0);
    repeat (5) begin @(posedge clk); #1; end
    check("final_drained", exp_wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bm_result_collector.md
Name: bm_result_collector

Overview:
- Downstream of the block-match control FSM and the left/right block-match cores.
- Accepts per-block match results (disparity, cost, 16-bit block index) from both cores and pairs them by index.
- Applies a left/right consistency check and a cost threshold.
- Writes one byte per block into a double-buffered disparity map RAM, and pulses frame_done when the last block of an image is written.

Parameters:
- center_blocks_per_row, 17, block columns per row (index col 0..16)
- blocks_per_col, 29, block rows per image
- num_pad_blocks, 2, columns below this index have no valid right result
- third_blocks_per_row, 15, columns at or above this index have no valid left result
- disp_w, 6, disparity width
- cost_w, 16, SAD cost width
- map_addr_w, 10, map RAM address width; must hold 2*17*29=986 entries

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- res_valid_left  in  1  left result strobe
- res_ready_left  out  1  left holding register empty
- res_index_left  in  16  {img[3:0], row[5:0], col[5:0]}
- res_disp_left  in  disp_w  left disparity
- res_cost_left  in  cost_w  left best cost
- res_valid_right, res_ready_right, res_index_right, res_disp_right, res_cost_right: same as left, for the right core
- lr_tol  in  disp_w  max |dl-dr| for consistency (quasi-static)
- max_cost  in  cost_w  cost threshold (quasi-static)
- map_wr_en  out  1  map write strobe
- map_wr_addr  out  map_addr_w  img[0]*493 + row*17 + col
- map_wr_data  out  8  {valid, 1'b0, disp}
- frame_done  out  1  one-cycle pulse after last block is written
- frame_img  out  4  img number of the completed frame
- err_mismatch  out  1  sticky: paired results had different indices

Behaviour:
- Reset values: all outputs 0 except res_ready_left/right = 1. Both holding registers are empty; err_mismatch is cleared.
- Handshake: a result is accepted on an edge where valid && ready. ready = !hold_valid. The two sides are independent and may arrive in either order or in the same cycle.
- Pair fire: on the edge where both holding regs are full.
  - Both hold regs are cleared.
  - The write register is loaded, so map_wr_en is high for exactly one cycle after that edge.
  - Latency is 2 cycles from the cycle a second valid is sampled to the map_wr_en cycle.
  - Throughput: at most one pair every 2 cycles.
- Index mismatch (both held, indices differ):
  - No write.
  - Both hold regs are cleared.
  - err_mismatch is set and stays set until reset.
- Valid bit, by column of the left index:
  - col < num_pad_blocks: valid = cost_l <= max_cost. Disparity is taken from the left result.
  - col >= third_blocks_per_row: valid = cost_r <= max_cost. Disparity is taken from the right result.
  - Otherwise: valid = cost_l <= max_cost && cost_r <= max_cost && |dl-dr| <= lr_tol. |dl-dr| is computed at disp_w+1 bits with no wrap. Disparity is taken from the left result.
  - Data is written even when valid = 0; map_wr_data then carries the disparity with bit 7 = 0.
- Address: computed from index fields using constant multipliers. Bank 0 is used when img[0]=0, bank 1 at offset 493 otherwise.
- Frame done:
  - Fires on the cycle map_wr_en writes row=blocks_per_col-1, col=center_blocks_per_row-1.
  - frame_done pulses on the cycle after that write; frame_img = img field of the last write.
  - Writes are not counted; only the last index triggers frame_done.
- Reset mid-operation: pending holds, write and pulse are discarded. No write or frame_done is produced for results accepted before reset.
- Out-of-range row/col: the write is suppressed and err_mismatch is set.

Decomposition:
- Shared package bm_pkg holds:
  - blk_index_t packed struct {img, row, col}
  - the geometry constants (17, 29, 2, 15, 493)
  - disp/cost widths
- One sub-module is natural: bm_lr_check, a combinational consistency/threshold check returning {valid, disp}. It is instantiated once between the hold regs and the write register.

Test Plan:
- Reset, then left idx 0x0000 (d=10, c=100) and right idx 0x0000 (d=11, c=90) in the same cycle, lr_tol=1, max_cost=500 -> 2 cycles later map_wr_en=1, addr=0, data=0x8A.
- Right arrives 5 cycles before left, idx {img=1,row=3,col=5}, d=20/24, lr_tol=2 -> res_ready_right=0 while waiting; write addr=493+56=549, data=0x14 (valid=0).
- Col 0 with right cost 0xFFFF, left cost 50, d=7 -> data=0x87; col 16 with left cost 0xFFFF, right d=9, c=40 -> data=0x89.
- Full frame of 493 pairs, img=2 -> exactly 493 writes, single frame_done pulse after the write at addr 492, frame_img=2, err_mismatch=0.
- Left idx 0x0041, right idx 0x0042 -> no write, err_mismatch=1 and stays high; next matching pair is still written.
- Assert reset while left is held -> ready=1, no write follows; a subsequent fresh pair writes normally.
